// File: rtl/mem_init_arbiter_if.sv
// Bus bundle between mem_init_arbiter and its surroundings: init ROM port,
// CPU port, RAM port and the init status flags.
// slave  : the arbiter's view (drives ROM address, RAM controls, status).
// master : the environment's view (ROM, CPU and RAM side).
interface mem_init_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  // Init ROM
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  // CPU
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we;
  logic              cpu_oe;
  logic              cpu_hold;
  // RAM
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic              ram_rden;
  logic [DATA_W-1:0] ram_q;
  // Status
  logic              init_done;
  logic              init_error;

  modport slave (
    output rom_addr,
    input  rom_data,
    input  cpu_addr, cpu_wdata, cpu_we, cpu_oe,
    output cpu_hold,
    output ram_addr, ram_data, ram_wren, ram_rden,
    input  ram_q,
    output init_done, init_error
  );

  modport master (
    input  rom_addr,
    output rom_data,
    output cpu_addr, cpu_wdata, cpu_we, cpu_oe,
    input  cpu_hold,
    input  ram_addr, ram_data, ram_wren, ram_rden,
    output ram_q,
    input  init_done, init_error
  );
endinterface

// File: rtl/mem_init_arbiter.sv
// mem_init_arbiter: after reset (or a reload request) copies INIT_DEPTH words
// from an init ROM into RAM starting at INIT_BASE, then hands the RAM port to
// the CPU as a combinational pass-through.
// Optional feature: define MEM_INIT_VERIFY_EN to add a VERIFY pass that reads
// the loaded window back and flags any mismatch on init_error (sticky until
// reset or reload). Without it init_error is tied low.
module mem_init_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int INIT_DEPTH = 64,
  parameter int INIT_BASE  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reload,
  mem_init_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(INIT_DEPTH - 1);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(INIT_BASE);

`ifdef MEM_INIT_VERIFY_EN
  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_RUN    = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd2
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

`ifdef MEM_INIT_VERIFY_EN
  logic [DATA_W-1:0] exp_q, exp_d;          // ROM word of the read in flight
  logic              cmp_vld_q, cmp_vld_d;  // ram_q this cycle answers last cycle's read
  logic              rd_done_q, rd_done_d;  // all reads issued, final compare pending
  logic              err_q, err_d;
`endif

  // Next-state, counter and RAM-port steering for every state.
  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no
    // path through the case below can leave one unassigned and infer a latch.
    state_d       = state_q;
    idx_d         = idx_q;
    bus.rom_addr  = idx_q;
    bus.ram_addr  = '0;
    bus.ram_data  = '0;
    bus.ram_wren  = 1'b0;
    bus.ram_rden  = 1'b0;
    bus.cpu_hold  = 1'b1;
    bus.init_done = 1'b0;
`ifdef MEM_INIT_VERIFY_EN
    exp_d     = exp_q;
    cmp_vld_d = 1'b0;
    rd_done_d = rd_done_q;
    err_d     = err_q;
`endif

    unique case (state_q)
      ST_LOAD: begin
        bus.ram_addr = BASE_ADDR + idx_q;
        bus.ram_data = bus.rom_data;
        bus.ram_wren = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
`ifdef MEM_INIT_VERIFY_EN
          rd_done_d = 1'b0;
          state_d   = ST_VERIFY;
`else
          state_d   = ST_RUN;
`endif
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end

`ifdef MEM_INIT_VERIFY_EN
      ST_VERIFY: begin
        // Issue reads while any remain; remember the ROM word for next cycle.
        if (!rd_done_q) begin
          bus.ram_addr = BASE_ADDR + idx_q;
          bus.ram_rden = 1'b1;
          exp_d        = bus.rom_data;
          cmp_vld_d    = 1'b1;
          if (idx_q == LAST_IDX) rd_done_d = 1'b1;
          else                   idx_d     = idx_q + ADDR_W'(1);
        end
        if (cmp_vld_q && (bus.ram_q != exp_q)) err_d = 1'b1;
        // With all reads issued this cycle holds the last compare.
        if (rd_done_q) begin
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
`endif

      ST_RUN: begin
        bus.ram_addr  = bus.cpu_addr;
        bus.ram_data  = bus.cpu_wdata;
        bus.ram_wren  = bus.cpu_we;
        bus.ram_rden  = bus.cpu_oe;
        bus.cpu_hold  = 1'b0;
        bus.init_done = 1'b1;
        if (reload) begin
          idx_d   = '0;
          state_d = ST_LOAD;
`ifdef MEM_INIT_VERIFY_EN
          err_d   = 1'b0;
`endif
        end
      end

      default: begin
        idx_d   = '0;
        state_d = ST_LOAD;
      end
    endcase

    // Reset forces the idle-load view on the outputs immediately.
    if (reset) begin
      bus.ram_wren  = 1'b0;
      bus.ram_rden  = 1'b0;
      bus.cpu_hold  = 1'b1;
      bus.init_done = 1'b0;
    end
  end

  // State and load/verify index registers.
  always_ff @(posedge clk) begin
    // NOTE: registers update with non-blocking assignments so every flop
    // samples the pre-edge values no matter how the blocks are ordered.
    if (reset) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

`ifdef MEM_INIT_VERIFY_EN
  // Verify control flags and the sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_vld_q <= 1'b0;
      rd_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cmp_vld_q <= cmp_vld_d;
      rd_done_q <= rd_done_d;
      err_q     <= err_d;
    end
  end

  // Expected-data pipeline register for the readback compare.
  always_ff @(posedge clk) begin
    // NOTE: exp_q is only looked at when cmp_vld_q is set, so it is a plain
    // data register and needs no reset.
    exp_q <= exp_d;
  end

  assign bus.init_error = err_q & ~reset;
`else
  assign bus.init_error = 1'b0;
`endif

endmodule

// File: doc/mem_init_arbiter.md
MEM_INIT_ARBITER -- requirements
Module: mem_init_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the RAM/ROM/CPU data width.
REQ-002 Parameter ADDR_W, default 10, SHALL set the RAM word-address width.
REQ-003 Parameter INIT_DEPTH, default 64, SHALL set the number of words loaded; legal range 1..2^ADDR_W.
REQ-004 Parameter INIT_BASE, default 0, SHALL set the first RAM address loaded; INIT_BASE+INIT_DEPTH <= 2^ADDR_W.
REQ-005 Clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 Reset  in  1  SHALL be a synchronous, active-high reset.
REQ-007 Reload  in  1  SHALL be a synchronous, active-high pulse that requests a reload while in RUN.
REQ-008 rom_addr  out  ADDR_W  SHALL be the init-ROM word index (0..INIT_DEPTH-1).
REQ-009 rom_data  in  DATA_W  SHALL be combinational ROM data for rom_addr.
REQ-010 cpu_addr  in  ADDR_W  SHALL be the CPU word address.
REQ-011 cpu_wdata  in  DATA_W  SHALL be the CPU write data.
REQ-012 cpu_we / cpu_oe  in  1 each  SHALL be the CPU write and read enables.
REQ-013 cpu_hold  out  1  SHALL be high whenever the CPU does not own the RAM.
REQ-014 ram_addr / ram_data  out  ADDR_W / DATA_W  SHALL drive the RAM address and write data.
REQ-015 ram_wren / ram_rden  out  1 each  SHALL drive the RAM write and read enables.
REQ-016 ram_q  in  DATA_W  SHALL be RAM read data, valid 1 cycle after ram_rden; the CPU also reads ram_q directly.
REQ-017 init_done / init_error  out  1 each  SHALL flag load completion and readback mismatch.

Function
REQ-018 FSM states SHALL be LOAD, VERIFY (only when compiled in), RUN.
REQ-019 In LOAD, a counter idx SHALL advance 0..INIT_DEPTH-1, one word per cycle.
- Outputs: rom_addr=idx, ram_addr=INIT_BASE+idx, ram_data=rom_data, ram_wren=1, ram_rden=0.
REQ-020 After the write at idx=INIT_DEPTH-1, the FSM SHALL go to VERIFY if compiled in, otherwise to RUN.
REQ-021 In RUN, the block SHALL pass CPU signals through combinationally.
- ram_addr=cpu_addr, ram_data=cpu_wdata, ram_wren=cpu_we, ram_rden=cpu_oe.
- cpu_hold=0, init_done=1.
REQ-022 In LOAD and VERIFY, cpu_hold SHALL be 1, init_done SHALL be 0, and CPU inputs SHALL be ignored.
REQ-023 Reload high in RUN SHALL clear idx and init_error and enter LOAD on the next cycle; Reload in LOAD or VERIFY SHALL be ignored.
REQ-024 Address arithmetic SHALL be ADDR_W bits wide, and idx SHALL never exceed INIT_DEPTH-1.
REQ-025 INIT_DEPTH=1 SHALL produce exactly one write cycle.

Reset
REQ-026 While Reset is high, the block SHALL hold state LOAD, idx=0, init_done=0, init_error=0, ram_wren=0, ram_rden=0, and cpu_hold=1.
REQ-027 The first write SHALL occur in the first cycle after Reset falls; Reset asserted mid-LOAD, mid-VERIFY or in RUN SHALL abort and restart from idx=0.

Configuration
REQ-028 With MEM_INIT_VERIFY_EN defined, VERIFY SHALL read INIT_BASE+idx for idx 0..INIT_DEPTH-1 (ram_rden=1, ram_wren=0) and compare each ram_q with the registered rom_data one cycle later.
- Any mismatch SHALL set init_error sticky until Reset or Reload.
- RUN SHALL be entered after the last compare.
REQ-029 Without MEM_INIT_VERIFY_EN, the VERIFY state and comparator SHALL be absent and init_error SHALL be tied to 0.

Verification
REQ-030 Defaults, Reset released at cycle 0 -> writes to addresses 0..63 in cycles 1..64 with ram_data=rom_data; init_done=1 from cycle 65 (verify off) or cycle 130 (verify on).
REQ-031 INIT_BASE=0x100, INIT_DEPTH=4 -> ram_wren=1 at addresses 0x100..0x103 only, then RUN.
REQ-032 In RUN, cpu_we=1, cpu_addr=0x005, cpu_wdata=0xBEEF -> ram_wren=1, ram_addr=0x005, ram_data=0xBEEF in the same cycle; cpu_hold=0.
REQ-033 Verify on, RAM model corrupts address 3 -> init_error=1 after that compare and stays 1 in RUN; Reload -> init_error=0 and LOAD restarts.
REQ-034 Reset pulsed at idx=30 -> idx returns to 0; the next write goes to INIT_BASE and exactly INIT_DEPTH writes follow before init_done.
REQ-035 Reload held during LOAD -> no effect; Reload pulsed in RUN -> cpu_hold=1 on the next cycle and full reload.
